// File: rtl/div32s_seq_hhp.sv
// Sequential signed divider: 2W-bit dividend / W-bit divisor -> 2W-bit quotient, W-bit remainder.
// Restoring division on magnitudes, STEPS quotient bits per cycle, valid/ready on both sides.
module div32s_seq_hhp #(
  parameter int W     = 16,
  parameter int STEPS = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] in_dividend,
  input  logic [W-1:0]   in_divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_quot,
  output logic [W-1:0]   out_rem,
  output logic           out_div0,
  output logic           out_ovf
);

  localparam int N    = 2 * W;
  localparam int NCYC = N / STEPS;
  localparam int CW   = $clog2(NCYC + 1);

  typedef enum logic [2:0] {IDLE, CHECK, ITER, FIX, DONE} state_t;

  state_t          state;
  logic [N-1:0]    dvd;      // operand, then magnitude, then quotient shifted in from the right
  logic [W-1:0]    dvs;
  logic [W:0]      rem;      // W+1 bits so |divisor| = 2^(W-1) compares without loss
  logic [W:0]      dmag;
  logic            neg_q;
  logic            neg_r;
  logic [CW-1:0]   cnt;

  logic [W:0]      rem_nxt;
  logic [N-1:0]    dvd_nxt;
  logic [W:0]      rem_sh;

  always_comb begin
    rem_nxt = rem;
    dvd_nxt = dvd;
    rem_sh  = '0;
    for (int i = 0; i < STEPS; i++) begin
      rem_sh  = {rem_nxt[W-1:0], dvd_nxt[N-1]};
      dvd_nxt = {dvd_nxt[N-2:0], 1'b0};
      if (rem_sh >= dmag) begin
        rem_sh     = rem_sh - dmag;
        dvd_nxt[0] = 1'b1;
      end
      rem_nxt = rem_sh;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_quot  <= '0;
      out_rem   <= '0;
      out_div0  <= 1'b0;
      out_ovf   <= 1'b0;
      dvd       <= '0;
      dvs       <= '0;
      rem       <= '0;
      dmag      <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvd      <= in_dividend;
            dvs      <= in_divisor;
            in_ready <= 1'b0;
            state    <= CHECK;
          end
        end
        CHECK: begin
          if (dvs == '0) begin
            out_quot  <= '1;
            out_rem   <= dvd[W-1:0];
            out_div0  <= 1'b1;
            out_ovf   <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (dvd == {1'b1, {(N-1){1'b0}}} && dvs == '1) begin
            out_quot  <= {1'b1, {(N-1){1'b0}}};
            out_rem   <= '0;
            out_div0  <= 1'b0;
            out_ovf   <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            neg_q <= dvd[N-1] ^ dvs[W-1];
            neg_r <= dvd[N-1];
            dvd   <= dvd[N-1] ? -dvd : dvd;
            dmag  <= dvs[W-1] ? ({1'b0, ~dvs} + (W+1)'(1)) : {1'b0, dvs};
            rem   <= '0;
            cnt   <= CW'(NCYC);
            state <= ITER;
          end
        end
        ITER: begin
          dvd <= dvd_nxt;
          rem <= rem_nxt;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          out_quot  <= neg_q ? -dvd : dvd;
          out_rem   <= neg_r ? -rem[W-1:0] : rem[W-1:0];
          out_div0  <= 1'b0;
          out_ovf   <= 1'b0;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
